// File: rtl/mccu.sv
// mccu: multi-cycle CPU control unit.
// Steps each instruction through IF/ID/EX/MEM/WB and talks to one shared
// memory over a req/ack handshake. A request that waits MEM_TIMEOUT cycles
// without an ack parks the FSM in FAULT until reset. MEM_TIMEOUT = 0 turns
// the timeout off.
// Optional feature: define MCCU_PERF_CNT_EN to add the retired_cnt
// instruction counter (CNT_W bits wide). Without the macro there is no
// counter and no port.
module mccu #(
  parameter int MEM_TIMEOUT = 16
`ifdef MCCU_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] op,
  input  logic        alu_zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        cu_iord,
  output logic        cu_wmem,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  cu_pcsource,
  output logic        cu_wreg,
  output logic        cu_m2reg,
  output logic        cu_shift,
  output logic        cu_aluimm,
  output logic        cu_sext,
  output logic [3:0]  cu_aluc,
  output logic        illegal,
  output logic        fault,
  output logic [2:0]  state
`ifdef MCCU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] retired_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID    = 3'd1,
    S_EX    = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_FAULT = 3'd7
  } state_t;

  // The wait counter counts 0..MEM_TIMEOUT-1; reaching the last value with
  // no ack is the timeout.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  state_t              state_reg;
  state_t              state_next;
  logic [WAIT_W-1:0]   wait_cnt_reg;
  logic                fault_reg;

  logic [5:0] opcode;
  logic [5:0] funct;
  assign opcode = op[11:6];
  assign funct  = op[5:0];

  // Decoded instruction class and ALU controls
  logic       dec_legal;
  logic       dec_nop;
  logic       dec_j;
  logic       dec_beq;
  logic       dec_bne;
  logic       dec_lw;
  logic       dec_sw;
  logic [3:0] dec_aluc;
  logic       dec_shift;
  logic       dec_aluimm;
  logic       dec_sext;

  // Decode the IR: instruction class plus the EX-stage ALU controls
  always_comb begin
    dec_legal  = 1'b0;
    dec_nop    = 1'b0;
    dec_j      = 1'b0;
    dec_beq    = 1'b0;
    dec_bne    = 1'b0;
    dec_lw     = 1'b0;
    dec_sw     = 1'b0;
    dec_aluc   = 4'b0000;
    dec_shift  = 1'b0;
    dec_aluimm = 1'b0;
    dec_sext   = 1'b0;
    case (opcode)
      6'b000000: begin
        // Only the all-zero word is a nop; other funct values are illegal
        if (funct == 6'b000000) begin
          dec_legal = 1'b1;
          dec_nop   = 1'b1;
        end
      end
      6'b000001: begin
        dec_legal = 1'b1;
        case (funct)
          6'b000001: dec_aluc = 4'b0000;
          6'b000010: dec_aluc = 4'b0001;
          6'b000100: dec_aluc = 4'b0010;
          6'b001000: dec_aluc = 4'b0011;
          6'b010000: dec_aluc = 4'b0100;
          default:   dec_legal = 1'b0;
        endcase
      end
      6'b000010: begin
        dec_legal = 1'b1;
        dec_shift = 1'b1;
        case (funct)
          6'b000001: dec_aluc = 4'b0101;
          6'b000010: dec_aluc = 4'b0110;
          6'b000011: dec_aluc = 4'b0111;
          default: begin
            dec_legal = 1'b0;
            dec_shift = 1'b0;
          end
        endcase
      end
      6'b000101: begin
        dec_legal  = 1'b1;
        dec_aluimm = 1'b1;
        dec_sext   = 1'b1;
        dec_aluc   = 4'b0000;
      end
      6'b001001: begin
        dec_legal  = 1'b1;
        dec_aluimm = 1'b1;
        dec_aluc   = 4'b0010;
      end
      6'b001010: begin
        dec_legal  = 1'b1;
        dec_aluimm = 1'b1;
        dec_aluc   = 4'b0011;
      end
      6'b001110: begin
        dec_legal  = 1'b1;
        dec_aluimm = 1'b1;
        dec_aluc   = 4'b1000;
      end
      6'b001100: begin
        dec_legal  = 1'b1;
        dec_lw     = 1'b1;
        dec_aluimm = 1'b1;
        dec_sext   = 1'b1;
        dec_aluc   = 4'b0000;
      end
      6'b001101: begin
        dec_legal  = 1'b1;
        dec_sw     = 1'b1;
        dec_aluimm = 1'b1;
        dec_sext   = 1'b1;
        dec_aluc   = 4'b0000;
      end
      6'b001111: begin
        dec_legal = 1'b1;
        dec_beq   = 1'b1;
        dec_aluc  = 4'b0001;
      end
      6'b010000: begin
        dec_legal = 1'b1;
        dec_bne   = 1'b1;
        dec_aluc  = 4'b0001;
      end
      6'b010010: begin
        dec_legal = 1'b1;
        dec_j     = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // A memory request is outstanding in IF and MEM. An ack in the same
  // cycle the counter reaches its limit still completes the request.
  logic in_req;
  logic time_out;
  assign in_req   = (state_reg == S_IF) || (state_reg == S_MEM);
  assign time_out = (MEM_TIMEOUT != 0) && in_req && !mem_ack &&
                    (wait_cnt_reg == WAIT_LAST);

  // Next-state selection
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IF: begin
        if (mem_ack)       state_next = S_ID;
        else if (time_out) state_next = S_FAULT;
      end
      S_ID: begin
        if (!dec_legal || dec_nop || dec_j) state_next = S_IF;
        else                                state_next = S_EX;
      end
      S_EX: begin
        if (dec_beq || dec_bne)    state_next = S_IF;
        else if (dec_lw || dec_sw) state_next = S_MEM;
        else                       state_next = S_WB;
      end
      S_MEM: begin
        if (mem_ack)       state_next = dec_sw ? S_IF : S_WB;
        else if (time_out) state_next = S_FAULT;
      end
      S_WB:    state_next = S_IF;
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_IF;
    endcase
  end

  // Datapath strobes; all of them drop while rst is high so that nothing
  // in flight (pc_we, cu_wreg, mem_req) leaks out of an aborted instruction
  always_comb begin
    mem_req     = 1'b0;
    cu_iord     = 1'b0;
    cu_wmem     = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    cu_pcsource = 2'b00;
    cu_wreg     = 1'b0;
    cu_m2reg    = 1'b0;
    cu_shift    = 1'b0;
    cu_aluimm   = 1'b0;
    cu_sext     = 1'b0;
    cu_aluc     = 4'b0000;
    illegal     = 1'b0;
    if (!rst) begin
      case (state_reg)
        S_IF: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
          end
        end
        S_ID: begin
          if (!dec_legal) begin
            illegal = 1'b1;
          end else if (dec_j) begin
            pc_we       = 1'b1;
            cu_pcsource = 2'b10;
          end
        end
        S_EX: begin
          cu_aluc   = dec_aluc;
          cu_shift  = dec_shift;
          cu_aluimm = dec_aluimm;
          cu_sext   = dec_sext;
          if (dec_beq) begin
            pc_we       = alu_zero;
            cu_pcsource = 2'b01;
          end else if (dec_bne) begin
            pc_we       = !alu_zero;
            cu_pcsource = 2'b01;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          cu_iord = 1'b1;
          cu_wmem = dec_sw;
        end
        S_WB: begin
          cu_wreg  = 1'b1;
          cu_m2reg = dec_lw;
        end
        default: ;
      endcase
    end
  end

  assign state = rst ? 3'd0 : state_reg;
  assign fault = fault_reg & ~rst;

  // FSM state, wait counter and sticky fault flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IF;
      wait_cnt_reg <= '0;
      fault_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg || mem_ack) begin
        wait_cnt_reg <= '0;
      end else if (in_req && MEM_TIMEOUT != 0) begin
        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
      end
      if (state_next == S_FAULT) begin
        fault_reg <= 1'b1;
      end
    end
  end

`ifdef MCCU_PERF_CNT_EN
  logic [CNT_W-1:0] retired_reg;

  // Count every return to IF from a later stage (illegal ops included)
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_reg <= '0;
    end else if ((state_reg == S_ID || state_reg == S_EX ||
                  state_reg == S_MEM || state_reg == S_WB) &&
                 state_next == S_IF) begin
      retired_reg <= retired_reg + CNT_W'(1);
    end
  end

  assign retired_cnt = retired_reg;
`endif

endmodule
